mux_scan_ctrl: RTL
==================

Name: mux_scan_ctrl

Overview:
Sequencer that drives the 4-bit select of the 16:1 8-bit mux and consumes its Y output. On a start pulse it walks the enabled channels in ascending order. For each channel it drives sel3..sel0, waits a settle interval, then samples Y. Each sample is presented downstream with its channel index on a valid/ready handshake.

Parameters:
- SETTLE, 1, cycles sel is held stable before Y is sampled; legal range 1..15.
- W, 8, data width of Y; must match the mux.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a scan; sampled only in IDLE
- stop  in  1  abort request; honoured only when MUX_SCAN_CONT_EN is defined
- ch_mask  in  16  channel enable mask; bit i enables X_i; captured at start
- y_in  in  W  Y output of the mux
- sel3, sel2, sel1, sel0  out  1 each  registered mux select; {sel3,sel2,sel1,sel0} = channel index
- out_data  out  W  sampled Y
- out_ch  out  4  channel index of out_data
- out_valid  out  1  out_data and out_ch are valid
- out_ready  in  1  downstream accepts the sample
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a scan completes

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, idx=0, sel=0000, out_data=0, out_ch=0, out_valid=0, busy=0, done=0, settle counter=0, mask register=0. rst has priority over all other inputs, including mid-scan and mid-handshake; a pending out_valid is dropped.
- States: IDLE, SEEK, WAIT, OUT, DONE.
- IDLE
  - start=1 and ch_mask!=0: mask_r<=ch_mask, idx<=0, go to SEEK.
  - start=1 and ch_mask==0: go to DONE; no samples are produced.
  - start=0: remain in IDLE.
- SEEK: tests one index per cycle.
  - mask_r[idx]=1: sel<=idx, cnt<=SETTLE-1, go to WAIT.
  - mask_r[idx]=0 and idx==15: go to DONE.
  - mask_r[idx]=0 otherwise: idx<=idx+1.
- WAIT: sel is held.
  - cnt!=0: cnt<=cnt-1.
  - cnt==0: out_data<=y_in, out_ch<=idx, out_valid<=1, go to OUT.
- OUT: out_data, out_ch and sel are held until out_valid & out_ready.
  - Transfer cycle: out_valid<=0.
  - After transfer with idx==15: go to DONE.
  - After transfer otherwise: idx<=idx+1, go to SEEK.
  - out_ready held low stalls the block indefinitely with outputs stable.
- DONE: done=1 for exactly one cycle, then IDLE. sel keeps the last driven value.
- Latency with SETTLE=1 and mask bit 0 set: start is sampled at edge E0. State is SEEK after E0. sel=0000 after E1. out_valid=1 after E2.
- General latency: out_valid rises SETTLE+1 edges after the SEEK cycle that hits an enabled channel.
- Skipping a disabled channel costs one cycle per index.
- ch_mask changes during a scan are ignored; only mask_r is used.
- start during busy is ignored.
- out_ready asserted while out_valid=0 has no effect.
- A full 16-channel scan with out_ready tied high takes 16*(SETTLE+2)+1 cycles from start to done.

Optional Feature:
- Macro: MUX_SCAN_CONT_EN.
- Defined (continuous scanning):
  - After the transfer for idx 15, or a SEEK miss at idx 15, idx wraps to 0 and the block returns to SEEK instead of DONE. Scanning repeats over mask_r indefinitely.
  - stop=1 is latched in any busy state. The scan ends at the next point that would otherwise wrap or begin a new SEEK; it never ends in mid-handshake. A pending OUT transfer completes first, then DONE pulses.
  - ch_mask==0 at start still goes straight to DONE.
- Undefined:
  - stop is ignored.
  - The block always ends in DONE after idx 15.
  - Port list is identical in both builds.

Test Plan:
- Mux loaded with X_0=0x00, X_2=0xFF, X_15=0xF0; ch_mask=0x8005, SETTLE=1, out_ready=1, start pulse -> three transfers: (ch0,0x00), (ch2,0xFF), (ch15,0xF0). sel equals out_ch at each transfer; done pulses once, then busy=0.
- ch_mask=0x0000, start -> done pulses on the second edge; out_valid never rises; sel stays 0000.
- ch_mask=0x0002 (X_1=0x01), out_ready=0 for 10 cycles then 1 -> out_valid held high 10+ cycles with out_data=0x01 and out_ch=1 stable; a single transfer, then done.
- SETTLE=3, ch_mask=0x0001 -> out_valid rises exactly 4 edges after the SEEK cycle. A y_in change 2 cycles after sel settles is captured.
- rst=1 asserted while in OUT with out_valid=1 -> next edge: out_valid=0, busy=0, sel=0000, state IDLE. A subsequent start restarts from ch0.
- MUX_SCAN_CONT_EN build, ch_mask=0x8001 -> sequence ch0, ch15, ch0, ch15 …. stop pulsed during ch0 WAIT -> ch0 still transfers, then done pulses; no ch15 sample follows.

Source files
------------

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 16:1 mux: walks enabled channels, settles, samples Y, hands off on valid/ready.
// Define MUX_SCAN_CONT_EN for continuous scanning with a stop request.
module mux_scan_ctrl #(
   parameter int SETTLE = 1,
   parameter int W      = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         stop,
   input  logic [15:0]  ch_mask,
   input  logic [W-1:0] y_in,
   output logic         sel3,
   output logic         sel2,
   output logic         sel1,
   output logic         sel0,
   output logic [W-1:0] out_data,
   output logic [3:0]   out_ch,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         busy,
   output logic         done
);

   typedef enum logic [2:0] {IDLE, SEEK, WAIT, OUT, DONE} state_t;

   localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

   state_t         state_reg, state_next;
   logic [3:0]     idx_reg, idx_next;
   logic [3:0]     sel_reg, sel_next;
   logic [3:0]     cnt_reg, cnt_next;
   logic [15:0]    mask_reg, mask_next;
   logic [W-1:0]   data_reg, data_next;
   logic [3:0]     ch_reg, ch_next;
   logic           valid_reg, valid_next;
   logic           stop_reg, stop_next;
   logic           stop_seen;

`ifdef MUX_SCAN_CONT_EN
   assign stop_seen = stop_reg | stop;
`else
   logic unused_stop;
   assign unused_stop = stop;
   assign stop_seen   = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         idx_reg   <= '0;
         sel_reg   <= '0;
         cnt_reg   <= '0;
         mask_reg  <= '0;
         data_reg  <= '0;
         ch_reg    <= '0;
         valid_reg <= 1'b0;
         stop_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
         sel_reg   <= sel_next;
         cnt_reg   <= cnt_next;
         mask_reg  <= mask_next;
         data_reg  <= data_next;
         ch_reg    <= ch_next;
         valid_reg <= valid_next;
         stop_reg  <= stop_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      sel_next   = sel_reg;
      cnt_next   = cnt_reg;
      mask_next  = mask_reg;
      data_next  = data_reg;
      ch_next    = ch_reg;
      valid_next = valid_reg;
      stop_next  = stop_reg;
      case (state_reg)
         IDLE: begin
            stop_next = 1'b0;
            if (start) begin
               if (ch_mask != 16'h0000) begin
                  mask_next  = ch_mask;
                  idx_next   = 4'd0;
                  state_next = SEEK;
               end else begin
                  state_next = DONE;
               end
            end
         end
         SEEK: begin
            if (mask_reg[idx_reg]) begin
               sel_next   = idx_reg;
               cnt_next   = SETTLE_M1;
               state_next = WAIT;
            end else if (stop_seen) begin
               state_next = DONE;
            end else if (idx_reg == 4'd15) begin
`ifdef MUX_SCAN_CONT_EN
               idx_next   = 4'd0;
`else
               state_next = DONE;
`endif
            end else begin
               idx_next = idx_reg + 4'd1;
            end
         end
         WAIT: begin
            if (cnt_reg != 4'd0) begin
               cnt_next = cnt_reg - 4'd1;
            end else begin
               data_next  = y_in;
               ch_next    = idx_reg;
               valid_next = 1'b1;
               state_next = OUT;
            end
         end
         OUT: begin
            // Everything is frozen until the downstream side takes the sample.
            if (valid_reg && out_ready) begin
               valid_next = 1'b0;
               if (stop_seen) begin
                  state_next = DONE;
               end else if (idx_reg == 4'd15) begin
`ifdef MUX_SCAN_CONT_EN
                  idx_next   = 4'd0;
                  state_next = SEEK;
`else
                  state_next = DONE;
`endif
               end else begin
                  idx_next   = idx_reg + 4'd1;
                  state_next = SEEK;
               end
            end
         end
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
`ifdef MUX_SCAN_CONT_EN
      if (state_reg != IDLE && stop) stop_next = 1'b1;
`endif
   end

   assign {sel3, sel2, sel1, sel0} = sel_reg;
   assign out_data  = data_reg;
   assign out_ch    = ch_reg;
   assign out_valid = valid_reg;
   assign busy      = (state_reg != IDLE);
   assign done      = (state_reg == DONE);

endmodule
